sync_fifo_param: RTL

Parametrised single-clock FIFO with configurable data width and power-of-two depth. Provides occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It is the general-purpose buffer between byte/word producers and consumers sharing one clock domain, and replaces fixed 8-bit/256-entry buffers. Read data is registered by default; first-word-fall-through is a compile option.

---
 rtl/sync_fifo_param_pkg.sv | 26 ++
 rtl/sync_fifo_param_if.sv | 37 +++
 rtl/sync_fifo_param_dpram.sv | 33 +++
 rtl/sync_fifo_param.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for sync_fifo_param: pointer-width helper, default
// geometry and parameter-legality helpers used by the FIFO top level.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 256;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // Geometry and threshold legality: depth is a power of two of at least 4,
    // and the almost-empty level sits strictly below almost-full.
    function automatic bit params_ok(input int width, input int depth,
                                     input int ae_level, input int af_level);
        return (width >= 1) && is_pow2(depth) && (depth >= 4) &&
               (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between sync_fifo_param and its producer/consumer.
// master: the side issuing writes/reads; slave: the FIFO itself.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);

    localparam int CW = ptr_w(DEPTH);

    logic             wen;
    logic [WIDTH-1:0] din;
    logic             ren;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output wen, din, ren, clr_err,
        input  dout, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wen, din, ren, clr_err,
        output dout, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_param_dpram.sv
// Simple dual-port RAM for the FIFO storage: one write port, one
// synchronous read port. No reset so it maps onto block RAM.
module fifo_dpram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] din,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= din;
        end
    end

    // Registered read port; output holds when ren is low.
    always_ff @(posedge clk) begin
        if (ren) begin
            dout <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags.
// Compile option FIFO_FWFT_EN selects first-word-fall-through output;
// without it, read data is registered and valid the cycle after ren.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst_,
    sync_fifo_param_if.slave  bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

    if (!params_ok(WIDTH, DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal WIDTH/DEPTH/AE_LEVEL/AF_LEVEL");
    end

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    count;
    logic [PW-1:0]    wptr_next;
    logic [PW-1:0]    rptr_next;
    logic [PW-1:0]    count_next;
    logic             wr_acc;
    logic             rd_acc;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
    logic             ram_ren;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_q;
    logic             live;

    // Accept decisions use registered flags only; next-state for pointers and count.
    always_comb begin
        wr_acc     = bus.wen && !full;
        rd_acc     = bus.ren && !empty;
        wptr_next  = wptr + {{(PW-1){1'b0}}, wr_acc};
        rptr_next  = rptr + {{(PW-1){1'b0}}, rd_acc};
        count_next = count + {{(PW-1){1'b0}}, wr_acc} - {{(PW-1){1'b0}}, rd_acc};
    end

    // Pointers, occupancy and status flags all move on the same edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wptr         <= wptr_next;
            rptr         <= rptr_next;
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.wen && full) begin
                overflow <= 1'b1;
            end else if (bus.clr_err) begin
                overflow <= 1'b0;
            end
            if (bus.ren && empty) begin
                underflow <= 1'b1;
            end else if (bus.clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .wen   (wr_acc),
        .waddr (wptr[AW-1:0]),
        .din   (bus.din),
        .ren   (ram_ren),
        .raddr (ram_raddr),
        .dout  (ram_q)
    );

`ifdef FIFO_FWFT_EN
    // Look-ahead read: the RAM always fetches the entry that will be at the
    // head after this edge. When that entry is being written on this same
    // edge the RAM returns stale data, so din is captured into a bypass
    // register and selected instead.
    logic             load;
    logic             byp_hit;
    logic             byp_sel;
    logic [WIDTH-1:0] byp_data;

    always_comb begin
        load      = (count_next != '0);
        byp_hit   = wr_acc && (wptr == rptr_next);
        ram_ren   = load;
        ram_raddr = rptr_next[AW-1:0];
    end

    // Head-select control; holds while the FIFO is (or becomes) empty.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            live    <= 1'b0;
            byp_sel <= 1'b0;
        end else if (load) begin
            live    <= 1'b1;
            byp_sel <= byp_hit;
        end
    end

    // Bypass data capture for a write landing directly at the head.
    always_ff @(posedge clk) begin
        if (load && byp_hit) begin
            byp_data <= bus.din;
        end
    end

    assign bus.dout = !live   ? '0 :
                      byp_sel ? byp_data : ram_q;
`else
    always_comb begin
        ram_ren   = rd_acc;
        ram_raddr = rptr[AW-1:0];
    end

    // Output is forced to zero until the first accepted read after reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            live <= 1'b0;
        end else if (rd_acc) begin
            live <= 1'b1;
        end
    end

    assign bus.dout = live ? ram_q : '0;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = almost_full;
    assign bus.almost_empty = almost_empty;
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule
